load_unit: RTL and testbench

Sequential load-side counterpart of the store path in the kianv multicycle core. It accepts a load request (funct3, byte address, AMO flag) and issues one or two word reads over the valid/ready memory handshake. It then aligns, merges and sign/zero-extends the result, and returns it with a one-cycle response strobe. It sits between the core's control FSM and the memory/cache port.

---
 rtl/load_unit_pkg.sv | 43 ++++
 rtl/load_unit_decoder.sv | 26 ++
 rtl/load_unit.sv | 132 +++++++++++++
 tb/tb_load_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared load-path types: load op encoding, FSM states and alignment helpers.
package load_unit_pkg;

  localparam int unsigned LOAD_OP_WIDTH = 3;

  typedef enum logic [LOAD_OP_WIDTH-1:0] {
    LOAD_OP_LB  = 3'd0,
    LOAD_OP_LH  = 3'd1,
    LOAD_OP_LW  = 3'd2,
    LOAD_OP_LBU = 3'd4,
    LOAD_OP_LHU = 3'd5
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } state_t;

  function automatic logic load_spans(input load_op_t op, input logic [1:0] k);
    case (op)
      LOAD_OP_LH, LOAD_OP_LHU: load_spans = (k == 2'd3);
      LOAD_OP_LW:              load_spans = (k != 2'd0);
      default:                 load_spans = 1'b0;
    endcase
  endfunction

  // words = {w1, w0}; shifting right by the byte offset covers every alignment case.
  function automatic logic [31:0] load_extract(input load_op_t op, input logic [1:0] k,
                                               input logic [63:0] words);
    logic [31:0] sh;
    sh = 32'(words >> {k, 3'b000});
    case (op)
      LOAD_OP_LB:  load_extract = {{24{sh[7]}}, sh[7:0]};
      LOAD_OP_LH:  load_extract = {{16{sh[15]}}, sh[15:0]};
      LOAD_OP_LBU: load_extract = {24'd0, sh[7:0]};
      LOAD_OP_LHU: load_extract = {16'd0, sh[15:0]};
      default:     load_extract = sh;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_decoder.sv
// Combinational load decoder: funct3 / AMO flag to load op plus illegal flag.
module load_decoder
  import load_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       amo_operation_load,
  output load_op_t   load_op,
  output logic       illegal
);

  always_comb begin
    load_op = LOAD_OP_LW;
    illegal = 1'b0;
    if (!amo_operation_load) begin
      case (funct3)
        3'b000:  load_op = LOAD_OP_LB;
        3'b001:  load_op = LOAD_OP_LH;
        3'b010:  load_op = LOAD_OP_LW;
        3'b100:  load_op = LOAD_OP_LBU;
        3'b101:  load_op = LOAD_OP_LHU;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_unit.sv
// Multicycle load unit: one or two word reads, then align/extend and respond.
// Optional LOAD_MISALIGNED_EN splits spanning non-AMO loads into two reads.
module load_unit
  import load_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        amo_operation_load,
  input  logic [31:0] addr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault
);

  state_t   state, state_nxt;
  load_op_t dec_op, op_q;
  logic     dec_illegal;
  logic     req_fire, req_spans, req_fault;
  logic [1:0] k_q;
`ifdef LOAD_MISALIGNED_EN
  logic        spans_q;
  logic [31:0] w0;
`endif

  load_decoder u_dec (
    .funct3             (funct3),
    .amo_operation_load (amo_operation_load),
    .load_op            (dec_op),
    .illegal            (dec_illegal)
  );

  assign req_fire  = req_valid && req_ready;
  assign req_spans = load_spans(dec_op, addr[1:0]);
`ifdef LOAD_MISALIGNED_EN
  assign req_fault = dec_illegal || (amo_operation_load && (addr[1:0] != 2'd0));
`else
  assign req_fault = dec_illegal || req_spans;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_fire) state_nxt = req_fault ? RESP : RD0;
      end
      RD0: begin
        mem_valid = 1'b1;
`ifdef LOAD_MISALIGNED_EN
        if (mem_ready) state_nxt = spans_q ? RD1 : RESP;
`else
        if (mem_ready) state_nxt = RESP;
`endif
      end
`ifdef LOAD_MISALIGNED_EN
      RD1: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      op_q      <= LOAD_OP_LW;
      k_q       <= '0;
`ifdef LOAD_MISALIGNED_EN
      spans_q   <= 1'b0;
      w0        <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_fire) begin
          op_q <= dec_op;
          k_q  <= addr[1:0];
`ifdef LOAD_MISALIGNED_EN
          spans_q <= req_spans;
`endif
          if (req_fault) begin
            rsp_fault <= 1'b1;
            rsp_data  <= '0;
          end else begin
            mem_addr <= {addr[31:2], 2'b00};
          end
        end
        RD0: if (mem_ready) begin
`ifdef LOAD_MISALIGNED_EN
          if (spans_q) begin
            w0       <= mem_rdata;
            mem_addr <= mem_addr + 32'd4;
          end else begin
            rsp_data  <= load_extract(op_q, k_q, {32'd0, mem_rdata});
            rsp_fault <= 1'b0;
          end
`else
          rsp_data  <= load_extract(op_q, k_q, {32'd0, mem_rdata});
          rsp_fault <= 1'b0;
`endif
        end
`ifdef LOAD_MISALIGNED_EN
        RD1: if (mem_ready) begin
          rsp_data  <= load_extract(op_q, k_q, {mem_rdata, w0});
          rsp_fault <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed, table-driven bench for load_unit (both LOAD_MISALIGNED_EN builds).
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic        amo;
  logic [31:0] addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  load_unit dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .funct3             (funct3),
    .amo_operation_load (amo),
    .addr               (addr),
    .mem_valid          (mem_valid),
    .mem_ready          (mem_ready),
    .mem_addr           (mem_addr),
    .mem_rdata          (mem_rdata),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .rsp_fault          (rsp_fault)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        amo;
    logic [31:0] addr;
    logic [31:0] w0;
    logic [31:0] w1;
    int unsigned waits;
    logic        fault;
    logic [31:0] data;
    int unsigned cyc;
    int unsigned reads;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [2:0] f3, logic a, logic [31:0] ad,
                              logic [31:0] w0, logic [31:0] w1, int unsigned waits,
                              logic fault, logic [31:0] data, int unsigned cyc,
                              int unsigned reads);
    vec_t v;
    v.name = name; v.f3 = f3; v.amo = a; v.addr = ad; v.w0 = w0; v.w1 = w1;
    v.waits = waits; v.fault = fault; v.data = data; v.cyc = cyc; v.reads = reads;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned rsp_cyc = 0;
    int unsigned reads   = 0;
    int unsigned waited  = 0;
    logic [31:0] exp_a0, exp_a1, prev_addr;
    logic prev_wait = 1'b0;
    logic addr_ok = 1'b1, stable_ok = 1'b1, busy_ok = 1'b1;
    exp_a0 = {v.addr[31:2], 2'b00};
    exp_a1 = exp_a0 + 32'd4;
    prev_addr = '0;
    @(negedge clk);
    req_valid = 1'b1; funct3 = v.f3; amo = v.amo; addr = v.addr; mem_ready = 1'b0;
    check({v.name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    for (int unsigned c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        rsp_cyc = c;
        break;
      end
      if (req_ready) busy_ok = 1'b0;
      if (mem_valid) begin
        if (prev_wait && (mem_addr !== prev_addr)) stable_ok = 1'b0;
        if (reads == 0 && mem_addr !== exp_a0) addr_ok = 1'b0;
        if (reads == 1 && mem_addr !== exp_a1) addr_ok = 1'b0;
        if (reads > 1) addr_ok = 1'b0;
        prev_addr = mem_addr;
        if (waited < v.waits) begin
          mem_ready = 1'b0; mem_rdata = 32'h5A5A5A5A; waited++; prev_wait = 1'b1;
        end else begin
          mem_ready = 1'b1; mem_rdata = (reads == 0) ? v.w0 : v.w1;
          reads++; waited = 0; prev_wait = 1'b0;
        end
      end else begin
        // unsolicited ready with junk data must be ignored
        mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0; prev_wait = 1'b0;
      end
    end
    check({v.name, " rsp cycle"}, rsp_cyc, v.cyc);
    check({v.name, " rsp_data"}, rsp_data, v.data);
    check({v.name, " rsp_fault"}, {31'd0, rsp_fault}, {31'd0, v.fault});
    check({v.name, " reads"}, reads, v.reads);
    check({v.name, " mem_addr seq"}, {31'd0, addr_ok}, 32'd1);
    check({v.name, " mem_addr stable"}, {31'd0, stable_ok}, 32'd1);
    check({v.name, " req_ready busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    check({v.name, " strobe one cycle"}, {31'd0, rsp_valid}, 32'd0);
    check({v.name, " req_ready after"}, {31'd0, req_ready}, 32'd1);
    check({v.name, " rsp_data held"}, rsp_data, v.data);
  endtask

  initial begin
    logic saw_rsp;
    rst = 1'b1; req_valid = 1'b0; funct3 = 3'b010; amo = 1'b0; addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    vecs.push_back(mk("lw_100",   3'b010, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 2, 1));
    vecs.push_back(mk("lb_103",   3'b000, 1'b0, 32'h00000103, 32'h80112233, 32'h0, 0, 1'b0, 32'hFFFFFF80, 2, 1));
    vecs.push_back(mk("lbu_103",  3'b100, 1'b0, 32'h00000103, 32'h80112233, 32'h0, 0, 1'b0, 32'h00000080, 2, 1));
`ifdef LOAD_MISALIGNED_EN
    vecs.push_back(mk("lh_203",   3'b001, 1'b0, 32'h00000203, 32'hAB000000, 32'h000000CD, 0, 1'b0, 32'hFFFFCDAB, 3, 2));
    vecs.push_back(mk("lw_wrap",  3'b010, 1'b0, 32'hFFFFFFFE, 32'hAABBCCDD, 32'h11223344, 1, 1'b0, 32'h3344AABB, 5, 2));
`else
    vecs.push_back(mk("lh_203",   3'b001, 1'b0, 32'h00000203, 32'hAB000000, 32'h000000CD, 0, 1'b1, 32'h00000000, 1, 0));
    vecs.push_back(mk("lw_wrap",  3'b010, 1'b0, 32'hFFFFFFFE, 32'hAABBCCDD, 32'h11223344, 1, 1'b1, 32'h00000000, 1, 0));
`endif
    vecs.push_back(mk("amo_202",  3'b000, 1'b1, 32'h00000202, 32'h12345678, 32'h0, 0, 1'b1, 32'h00000000, 1, 0));
    vecs.push_back(mk("f3_011",   3'b011, 1'b0, 32'h00000100, 32'h12345678, 32'h0, 0, 1'b1, 32'h00000000, 1, 0));
    vecs.push_back(mk("lw_wait3", 3'b010, 1'b0, 32'h00000100, 32'h12345678, 32'h0, 3, 1'b0, 32'h12345678, 5, 1));
    vecs.push_back(mk("lhu_102",  3'b101, 1'b0, 32'h00000102, 32'h87654321, 32'h0, 0, 1'b0, 32'h00008765, 2, 1));
    vecs.push_back(mk("lh_101",   3'b001, 1'b0, 32'h00000101, 32'h00F00D00, 32'h0, 0, 1'b0, 32'hFFFFF00D, 2, 1));
    vecs.push_back(mk("amo_lw",   3'b111, 1'b1, 32'h00000300, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'hCAFEF00D, 2, 1));
    vecs.push_back(mk("f3_110",   3'b110, 1'b0, 32'h00000040, 32'h0, 32'h0, 0, 1'b1, 32'h00000000, 1, 0));
    vecs.push_back(mk("f3_111",   3'b111, 1'b0, 32'h00000040, 32'h0, 32'h0, 0, 1'b1, 32'h00000000, 1, 0));
    vecs.push_back(mk("lbu_0",    3'b100, 1'b0, 32'h00000000, 32'h000000FE, 32'h0, 1, 1'b0, 32'h000000FE, 3, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_fault", {31'd0, rsp_fault}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while waiting in RD0
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b010; amo = 1'b0; addr = 32'h00000400; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid mem_valid before", {31'd0, mem_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_valid) saw_rsp = 1'b1;
    end
    mem_ready = 1'b0;
    check("rst_mid no activity", {31'd0, saw_rsp}, 32'd0);

    run_vec(mk("lw_after_rst", 3'b010, 1'b0, 32'h00000404, 32'h0BADF00D, 32'h0, 0, 1'b0, 32'h0BADF00D, 2, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
